// File: rtl/axis_avg_pkg.sv
// Shared constants and types for the block-averaging decimator.
package axis_avg_pkg;

    localparam int unsigned ACC_W     = 48;
    localparam int unsigned MAX_SHIFT = 16;
    localparam int unsigned CNT_W     = 17;

    // word0 field layout of the configuration bus
    localparam int unsigned SHIFT_LSB = 0;
    localparam int unsigned SHIFT_W   = 5;
    localparam int unsigned EN_BIT    = 8;

    typedef enum logic {
        StIdle,
        StAccum
    } state_e;

endpackage

// File: rtl/axis_minmax_track.sv
// Signed running min/max register pair. min_o/max_o already include sample_i,
// so the owner can capture the final block result in the same cycle.
module axis_minmax_track #(
    parameter int unsigned Width = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    seed_i,
    input  logic                    update_i,
    input  logic signed [Width-1:0] sample_i,
    output logic signed [Width-1:0] min_o,
    output logic signed [Width-1:0] max_o
);

    logic signed [Width-1:0] min_q, min_d;
    logic signed [Width-1:0] max_q, max_d;

    // Ties keep the stored value; a seed ignores the stale registers entirely.
    always_comb begin
        min_o = seed_i ? sample_i : ((sample_i < min_q) ? sample_i : min_q);
        max_o = seed_i ? sample_i : ((sample_i > max_q) ? sample_i : max_q);
    end

    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (clear_i) begin
            min_d = '0;
            max_d = '0;
        end else if (update_i) begin
            min_d = min_o;
            max_d = max_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            min_q <= '0;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

endmodule

// File: rtl/axis_stream_averager.sv
// Averages 2^SHIFT consecutive valid samples and emits avg/min/max once per block.
module axis_stream_averager
    import axis_avg_pkg::*;
#(
    parameter int unsigned SAXIS_TDATA_WIDTH     = 32,
    parameter int unsigned MAXIS_TDATA_WIDTH     = 32,
    parameter logic [31:0] configuration_address = 32'd2001
) (
    input  logic                         a_clk,
    input  logic                         a_rst,
    input  logic [31:0]                  config_addr,
    input  logic [511:0]                 config_data,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                         S_AXIS_tvalid,
    output logic [MAXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                         M_AXIS_tvalid,
    output logic [MAXIS_TDATA_WIDTH-1:0] M_AXIS_MIN_tdata,
    output logic [MAXIS_TDATA_WIDTH-1:0] M_AXIS_MAX_tdata,
    output logic [31:0]                  block_count
);

    logic [31:0]        word0;
    logic               cfg_wr;
    logic [SHIFT_W-1:0] shift_raw;
    logic [SHIFT_W-1:0] shift_cfg;
    logic               en_cfg;
    logic               unused_cfg;

    state_e                  state_q;
    logic [SHIFT_W-1:0]      shift_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [MAXIS_TDATA_WIDTH-1:0] avg_q, min_q, max_q;
    logic                    valid_q;
    logic [31:0]             block_count_q;

    logic signed [ACC_W-1:0]             sample_ext;
    logic signed [ACC_W-1:0]             sum;
    logic signed [ACC_W-1:0]             avg_full;
    logic [CNT_W-1:0]                    last_cnt;
    logic                                accept;
    logic                                last;
    logic signed [SAXIS_TDATA_WIDTH-1:0] blk_min, blk_max;

    assign word0      = config_data[31:0];
    assign cfg_wr     = (config_addr == configuration_address);
    assign shift_raw  = word0[SHIFT_LSB +: SHIFT_W];
    assign shift_cfg  = (shift_raw > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : shift_raw;
    assign en_cfg     = word0[EN_BIT];
    assign unused_cfg = ^{config_data[511:32], word0[31:EN_BIT+1], word0[EN_BIT-1:SHIFT_W]};

    assign sample_ext = {{(ACC_W - SAXIS_TDATA_WIDTH){S_AXIS_tdata[SAXIS_TDATA_WIDTH-1]}},
                         S_AXIS_tdata};
    assign sum        = acc_q + sample_ext;
    assign avg_full   = sum >>> shift_q;
    assign last_cnt   = (CNT_W'(1) << shift_q) - CNT_W'(1);

    // A sample coinciding with a config write is dropped.
    assign accept = (state_q == StAccum) && S_AXIS_tvalid && !cfg_wr;
    assign last   = (cnt_q == last_cnt);

    axis_minmax_track #(
        .Width (SAXIS_TDATA_WIDTH)
    ) u_minmax (
        .clk_i    (a_clk),
        .rst_i    (a_rst),
        .clear_i  (cfg_wr | (accept & last)),
        .seed_i   (accept & (cnt_q == '0)),
        .update_i (accept),
        .sample_i (S_AXIS_tdata),
        .min_o    (blk_min),
        .max_o    (blk_max)
    );

    always_ff @(posedge a_clk or posedge a_rst) begin
        if (a_rst) begin
            state_q       <= StIdle;
            shift_q       <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            avg_q         <= '0;
            min_q         <= '0;
            max_q         <= '0;
            valid_q       <= 1'b0;
            block_count_q <= '0;
        end else begin
            valid_q <= 1'b0;
            if (cfg_wr) begin
                // Any write, even an identical one, drops the block in progress.
                shift_q <= shift_cfg;
                state_q <= en_cfg ? StAccum : StIdle;
                acc_q   <= '0;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StAccum: begin
                        if (S_AXIS_tvalid) begin
                            if (last) begin
                                avg_q         <= avg_full[MAXIS_TDATA_WIDTH-1:0];
                                min_q         <= blk_min;
                                max_q         <= blk_max;
                                valid_q       <= 1'b1;
                                block_count_q <= block_count_q + 32'd1;
                                acc_q         <= '0;
                                cnt_q         <= '0;
                            end else begin
                                acc_q <= sum;
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign M_AXIS_tdata     = avg_q;
    assign M_AXIS_MIN_tdata = min_q;
    assign M_AXIS_MAX_tdata = max_q;
    assign M_AXIS_tvalid    = valid_q;
    assign block_count      = block_count_q;

endmodule

// File: tb/tb_axis_stream_averager.sv
// Directed bench: a reference model pushes expected block results, a monitor pops and checks.
module tb_axis_stream_averager;
    import axis_avg_pkg::*;

    logic         a_clk = 1'b0;
    logic         a_rst = 1'b1;
    logic [31:0]  config_addr = '0;
    logic [511:0] config_data = '0;
    logic [31:0]  S_AXIS_tdata = '0;
    logic         S_AXIS_tvalid = 1'b0;
    logic [31:0]  M_AXIS_tdata, M_AXIS_MIN_tdata, M_AXIS_MAX_tdata, block_count;
    logic         M_AXIS_tvalid;

    axis_stream_averager dut (
        .a_clk            (a_clk),
        .a_rst            (a_rst),
        .config_addr      (config_addr),
        .config_data      (config_data),
        .S_AXIS_tdata     (S_AXIS_tdata),
        .S_AXIS_tvalid    (S_AXIS_tvalid),
        .M_AXIS_tdata     (M_AXIS_tdata),
        .M_AXIS_tvalid    (M_AXIS_tvalid),
        .M_AXIS_MIN_tdata (M_AXIS_MIN_tdata),
        .M_AXIS_MAX_tdata (M_AXIS_MAX_tdata),
        .block_count      (block_count)
    );

    always #5 a_clk = ~a_clk;

    typedef struct {
        logic [31:0] avg;
        logic [31:0] mn;
        logic [31:0] mx;
        logic [31:0] bc;
        longint      cyc;
    } exp_t;

    exp_t   sb[$];
    exp_t   last_exp;
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    // Reference model state
    bit     m_en = 0;
    int     m_shift = 0;
    int     m_cnt = 0;
    longint m_acc = 0;
    int     m_min = 0;
    int     m_max = 0;
    int     m_blocks = 0;

    always @(posedge a_clk) cyc <= cyc + 1;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge a_clk) begin
        if (!a_rst && M_AXIS_tvalid) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_pulse observed=pulse expected=none avg=0x%08h", M_AXIS_tdata);
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                assert (cyc === e.cyc) else begin
                    errors++;
                    $error("FAIL pulse_cycle observed=%0d expected=%0d", cyc, e.cyc);
                end
                chk32("avg", M_AXIS_tdata, e.avg);
                chk32("min", M_AXIS_MIN_tdata, e.mn);
                chk32("max", M_AXIS_MAX_tdata, e.mx);
                chk32("block_count", block_count, e.bc);
            end
        end
    end

    task automatic model_clear();
        m_cnt = 0;
        m_acc = 0;
    endtask

    task automatic cfg(input int unsigned shift, input bit en,
                       input bit with_sample = 1'b0, input int s = 0);
        @(negedge a_clk);
        config_addr       = 32'd2001;
        config_data       = '0;
        config_data[4:0]  = shift[4:0];
        config_data[8]    = en;
        S_AXIS_tvalid     = with_sample;
        S_AXIS_tdata      = s;
        m_en    = en;
        m_shift = (shift[4:0] > 16) ? 16 : int'(shift[4:0]);
        model_clear();
        @(posedge a_clk);
        #1;
        config_addr   = '0;
        S_AXIS_tvalid = 1'b0;
    endtask

    task automatic send(input int s);
        @(negedge a_clk);
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata  = s;
        if (m_en) begin
            if (m_cnt == 0) begin
                m_min = s;
                m_max = s;
            end else begin
                if (s < m_min) m_min = s;
                if (s > m_max) m_max = s;
            end
            m_acc = m_acc + longint'(s);
            m_cnt++;
            if (m_cnt == (1 << m_shift)) begin
                exp_t e;
                longint q;
                q = m_acc >>> m_shift;
                m_blocks++;
                e.avg = q[31:0];
                e.mn  = m_min;
                e.mx  = m_max;
                e.bc  = m_blocks;
                e.cyc = cyc + 1;
                sb.push_back(e);
                last_exp = e;
                model_clear();
            end
        end
        @(posedge a_clk);
        #1;
        S_AXIS_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge a_clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        last_exp = '{avg: '0, mn: '0, mx: '0, bc: '0, cyc: 0};
        idle(3);
        chk32("rst_avg", M_AXIS_tdata, 32'd0);
        chk32("rst_min", M_AXIS_MIN_tdata, 32'd0);
        chk32("rst_max", M_AXIS_MAX_tdata, 32'd0);
        chk32("rst_valid", {31'd0, M_AXIS_tvalid}, 32'd0);
        chk32("rst_block_count", block_count, 32'd0);
        a_rst = 1'b0;
        idle(2);

        // Basic block of four
        cfg(2, 1);
        send(1); send(2); send(3); send(4);
        idle(3);
        chk32("block_count_after_first", block_count, 32'd1);

        // Negative values, floor rounding
        cfg(1, 1);
        send(-1); send(-2);
        idle(3);

        // Pass-through with continuous valid
        cfg(0, 1);
        send(5); send(7); send(9);
        idle(3);

        // Restart mid-block, coincident sample dropped, gaps stall
        cfg(2, 1);
        send(1); send(2); send(3);
        cfg(2, 1, 1'b1, 99);
        send(10); idle(2); send(10); send(10); idle(1); send(10);
        idle(3);

        // Shift clamp and full-scale accumulation
        cfg(31, 1);
        for (int i = 0; i < 65536; i++) send(32'h7FFF_FFFF);
        idle(3);

        // Disabled: samples ignored, outputs hold
        cfg(1, 0);
        send(40); send(50); send(60);
        idle(3);
        chk32("hold_avg_disabled", M_AXIS_tdata, last_exp.avg);
        chk32("hold_bc_disabled", block_count, last_exp.bc);

        // Asynchronous reset mid-block
        cfg(2, 1);
        send(5); send(6);
        #2;
        a_rst = 1'b1;
        m_en = 0; m_shift = 0; m_blocks = 0;
        model_clear();
        #2;
        chk32("arst_avg", M_AXIS_tdata, 32'd0);
        chk32("arst_min", M_AXIS_MIN_tdata, 32'd0);
        chk32("arst_max", M_AXIS_MAX_tdata, 32'd0);
        chk32("arst_block_count", block_count, 32'd0);
        chk32("arst_state", {31'd0, dut.state_q == StIdle}, 32'd1);
        @(negedge a_clk);
        a_rst = 1'b0;
        send(1); send(2); send(3); send(4);
        idle(3);
        chk32("post_rst_avg_hold", M_AXIS_tdata, 32'd0);

        cfg(2, 1);
        send(8); send(-8); send(4); send(0);
        idle(3);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL missing_pulses observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
